// File: rtl/ddhw_serial_pkg.sv
// Shared types and framing constants for the serial receive stage.
package ddhw_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial-in/parallel-out register, LSB-first (new bit enters at the MSB).
module sipo_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shreg_q;

  // Shift right on enable so the first bit taken ends up in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else if (shift_en_i) begin
      shreg_q <= {d_i, shreg_q[WIDTH-1:1]};
    end
  end

  assign q_o = shreg_q;

endmodule

// File: rtl/serial_byte_assembler.sv
// Start-bit framed serial receiver with valid/ready output, framing-error and overrun flags.
module serial_byte_assembler
  import ddhw_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg;
  logic             shift_en;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  assign shift_en = (state_q == DATA) && en;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (shift_en),
    .d_i        (d),
    .q_o        (shreg)
  );

  // FSM state and bit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; only enabled cycles advance the frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (d == START_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = STOP;
          end
        end
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output next values: handshake drain, word load, overrun and framing error.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    if (en && (state_q == STOP)) begin
      if (d == STOP_BIT) begin
        if (!out_valid_q || out_ready) begin
          out_data_d  = shreg;
          out_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
